pc_flag_unit: RTL and testbench

Sequential program-counter and condition-flag stage that consumes the 16-bit CLA's `Sum` and `Ovfl` outputs. It registers the Z/V/N flags written by ALU operations and evaluates the 3-bit branch condition against them. It advances the PC by 2, to a PC-relative target, or to a register target, and holds the PC once HLT is decoded. It sits between the execute-stage adder and the instruction-fetch address.

---
 rtl/wisc_pkg.sv | 21 ++
 rtl/CLA.sv | 46 ++++
 rtl/branch_cond.sv | 27 ++
 rtl/pc_flag_unit.sv | 104 ++++++++++
 tb/tb_pc_flag_unit.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/wisc_pkg.sv
// Shared constants for the WISC execute/fetch boundary: branch condition codes,
// reset PC and the halt state encoding.
package wisc_pkg;

    localparam logic [2:0] CCC_NE  = 3'b000;
    localparam logic [2:0] CCC_EQ  = 3'b001;
    localparam logic [2:0] CCC_GT  = 3'b010;
    localparam logic [2:0] CCC_LT  = 3'b011;
    localparam logic [2:0] CCC_GTE = 3'b100;
    localparam logic [2:0] CCC_LTE = 3'b101;
    localparam logic [2:0] CCC_OV  = 3'b110;
    localparam logic [2:0] CCC_UNC = 3'b111;

    localparam logic [15:0] PC_RESET = 16'h0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } halt_state_e;

endpackage

// File: rtl/CLA.sv
// 16-bit carry-lookahead adder/subtractor built from four 4-bit lookahead groups.
// Sub=1 computes A - B; Ovfl flags signed overflow.
module CLA (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        sub,
    output logic [15:0] Sum,
    output logic        Ovfl
);

    logic [15:0] b_eff;
    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;

    assign b_eff = B ^ {16{sub}};
    assign g     = A & b_eff;
    assign p     = A ^ b_eff;

    always_comb begin
        logic [4:0] cg;
        logic       gg;
        logic       gp;
        c     = '0;
        cg    = '0;
        cg[0] = sub;
        for (int j = 0; j < 4; j++) begin
            gg = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp = &p[4*j +: 4];
            cg[j+1] = gg | (gp & cg[j]);
            // Bit carries inside a group hang off that group's lookahead carry-in.
            c[4*j] = cg[j];
            for (int k = 0; k < 3; k++) begin
                c[4*j+k+1] = g[4*j+k] | (p[4*j+k] & c[4*j+k]);
            end
        end
        c[16] = cg[4];
    end

    assign Sum  = p ^ c[15:0];
    assign Ovfl = (A[15] ~^ b_eff[15]) & (Sum[15] ^ A[15]);

endmodule

// File: rtl/branch_cond.sv
// Decodes the 3-bit branch condition code against the registered Z/V/N flags.
module branch_cond
    import wisc_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic       flag_z,
    input  logic       flag_v,
    input  logic       flag_n,
    output logic       cond_met
);

    always_comb begin
        cond_met = 1'b0;
        unique case (ccc)
            CCC_NE:  cond_met = ~flag_z;
            CCC_EQ:  cond_met = flag_z;
            CCC_GT:  cond_met = ~flag_z & ~flag_n;
            CCC_LT:  cond_met = flag_n;
            CCC_GTE: cond_met = flag_z | ~flag_n;
            CCC_LTE: cond_met = flag_n | flag_z;
            CCC_OV:  cond_met = flag_v;
            CCC_UNC: cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_flag_unit.sv
// Program counter and Z/V/N flag stage: sequential fetch, PC-relative and
// register branches, and a sticky halt that freezes the PC until reset.
module pc_flag_unit
    import wisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] alu_result,
    input  logic        alu_ovfl,
    input  logic        flag_wr_all,
    input  logic        flag_wr_z,
    input  logic        branch,
    input  logic        branch_reg,
    input  logic [2:0]  ccc,
    input  logic [8:0]  imm9,
    input  logic [15:0] rs_data,
    input  logic        halt,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        flag_z,
    output logic        flag_v,
    output logic        flag_n,
    output logic        taken,
    output logic        halted
);

    halt_state_e state;
    logic [15:0] br_offset;
    logic [15:0] br_target;
    logic [15:0] next_pc;
    logic        cond_met;
    logic        ovfl_inc;
    logic        ovfl_tgt;
    logic        unused_ovfl;

    // Word offset scaled to bytes; wrap-around of the target add is intentional.
    assign br_offset   = {{6{imm9[8]}}, imm9, 1'b0};
    assign unused_ovfl = ovfl_inc ^ ovfl_tgt;
    assign halted      = (state == ST_HALT);

    CLA u_pc_inc (
        .A    (pc),
        .B    (16'h0002),
        .sub  (1'b0),
        .Sum  (pc_plus2),
        .Ovfl (ovfl_inc)
    );

    CLA u_br_add (
        .A    (pc_plus2),
        .B    (br_offset),
        .sub  (1'b0),
        .Sum  (br_target),
        .Ovfl (ovfl_tgt)
    );

    branch_cond u_cond (
        .ccc      (ccc),
        .flag_z   (flag_z),
        .flag_v   (flag_v),
        .flag_n   (flag_n),
        .cond_met (cond_met)
    );

    assign taken = (branch | branch_reg) & cond_met & en & ~halted & ~halt;

    always_comb begin
        next_pc = pc_plus2;
        if (halted || halt || !en) begin
            next_pc = pc;
        end else if (taken && branch_reg) begin
            next_pc = rs_data;
        end else if (taken) begin
            next_pc = br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= PC_RESET;
            flag_z <= 1'b0;
            flag_v <= 1'b0;
            flag_n <= 1'b0;
            state  <= ST_RUN;
        end else begin
            pc <= next_pc;
            // Flags still update on the HLT cycle itself; only the halted state blocks them.
            if (en && state == ST_RUN) begin
                if (flag_wr_all) begin
                    flag_z <= (alu_result == 16'h0000);
                    flag_v <= alu_ovfl;
                    flag_n <= alu_result[15];
                end else if (flag_wr_z) begin
                    flag_z <= (alu_result == 16'h0000);
                end
                if (halt) begin
                    state <= ST_HALT;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_flag_unit.sv
// Self-checking bench for pc_flag_unit: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_pc_flag_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] alu_result;
    logic        alu_ovfl;
    logic        flag_wr_all;
    logic        flag_wr_z;
    logic        branch;
    logic        branch_reg;
    logic [2:0]  ccc;
    logic [8:0]  imm9;
    logic [15:0] rs_data;
    logic        halt;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;
    logic        taken;
    logic        halted;

    int passed = 0;
    int total  = 0;

    pc_flag_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .alu_result  (alu_result),
        .alu_ovfl    (alu_ovfl),
        .flag_wr_all (flag_wr_all),
        .flag_wr_z   (flag_wr_z),
        .branch      (branch),
        .branch_reg  (branch_reg),
        .ccc         (ccc),
        .imm9        (imm9),
        .rs_data     (rs_data),
        .halt        (halt),
        .pc          (pc),
        .pc_plus2    (pc_plus2),
        .flag_z      (flag_z),
        .flag_v      (flag_v),
        .flag_n      (flag_n),
        .taken       (taken),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    endtask

    // ---------------- behavioural model ----------------
    int m_pc;
    bit m_z, m_v, m_n, m_halted, m_valid;

    function automatic bit cond_ok(input logic [2:0] c, input bit z, input bit v, input bit n);
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit model_taken();
        return (branch || branch_reg) && cond_ok(ccc, m_z, m_v, m_n) && en && !m_halted && !halt;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc = 0; m_z = 0; m_v = 0; m_n = 0; m_halted = 0; m_valid = 1;
        end else if (m_valid && en && !m_halted) begin
            bit tk;
            int off;
            tk  = model_taken();
            off = imm9[8] ? (int'(imm9) - 512) : int'(imm9);
            if (halt)                 m_halted = 1;
            else if (tk && branch_reg) m_pc = int'(rs_data);
            else if (tk)              m_pc = (m_pc + 2 + 2 * off) & 16'hFFFF;
            else                      m_pc = (m_pc + 2) & 16'hFFFF;
            if (flag_wr_all) begin
                m_z = (alu_result == 0); m_v = alu_ovfl; m_n = alu_result[15];
            end else if (flag_wr_z) begin
                m_z = (alu_result == 0);
            end
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_pc",       int'(pc),       m_pc);
            check("model_pc_plus2", int'(pc_plus2), (m_pc + 2) & 16'hFFFF);
            check("model_flags",    int'({flag_z, flag_v, flag_n}), int'({m_z, m_v, m_n}));
            check("model_halted",   int'(halted),   int'(m_halted));
            check("model_taken",    int'(taken),    int'(model_taken()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        en = 1; alu_result = 16'h1234; alu_ovfl = 0; flag_wr_all = 0; flag_wr_z = 0;
        branch = 0; branch_reg = 0; ccc = 3'd0; imm9 = 9'd0; rs_data = 16'h0; halt = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0;
        idle();
        step();
        rst_n = 1;
        check("reset_pc", int'(pc), 16'h0000);
        check("reset_flags", int'({flag_z, flag_v, flag_n, halted}), 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("seq_pc", int'(pc), 2 * i);
        end

        // Flag write of N/V while jumping to 0x0010.
        flag_wr_all = 1; alu_result = 16'h8000; alu_ovfl = 1;
        branch_reg = 1; ccc = 3'b111; rs_data = 16'h0010;
        step(); idle();
        check("wr_all_flags", int'({flag_z, flag_v, flag_n}), 3'b011);
        check("br_reg_pc", int'(pc), 16'h0010);
        branch = 1; ccc = 3'b110; imm9 = 9'h1FE;
        #1 check("ov_taken", int'(taken), 1);
        step(); idle();
        check("ov_target", int'(pc), 16'h000E);
        branch = 1; ccc = 3'b001;
        #1 check("eq_not_taken", int'(taken), 0);
        step(); idle();
        check("eq_seq", int'(pc), 16'h0010);

        flag_wr_z = 1; alu_result = 16'h0000;
        step(); idle();
        check("wr_z_flags", int'({flag_z, flag_v, flag_n}), 3'b111);
        branch = 1; ccc = 3'b101; imm9 = 9'd4;
        #1 check("lte_taken", int'(taken), 1);
        step(); idle();
        check("lte_target", int'(pc), 16'h001C);
        branch = 1; ccc = 3'b010;
        #1 check("gt_not_taken", int'(taken), 0);
        step(); idle();
        check("gt_seq", int'(pc), 16'h001E);

        branch_reg = 1; ccc = 3'b111; rs_data = 16'hFFFE;
        step(); idle();
        check("wrap_target", int'(pc), 16'hFFFE);
        step();
        check("wrap_seq", int'(pc), 16'h0000);

        en = 0; flag_wr_all = 1; alu_result = 16'h0000; alu_ovfl = 0; branch = 1; ccc = 3'b111;
        #1 check("stall_taken", int'(taken), 0);
        step();
        check("stall_pc", int'(pc), 16'h0000);
        check("stall_flags", int'({flag_z, flag_v, flag_n, halted}), 4'b1110);
        idle();

        branch_reg = 1; ccc = 3'b111; rs_data = 16'h0020;
        step(); idle();
        halt = 1; branch = 1; ccc = 3'b111; imm9 = 9'd8;
        #1 check("halt_taken", int'(taken), 0);
        step();
        check("halted_rise", int'(halted), 1);
        for (int i = 0; i < 10; i++) begin
            en = 1'($urandom); branch = 1'($urandom); branch_reg = 1'($urandom);
            ccc = 3'($urandom); rs_data = 16'($urandom); halt = 1'($urandom);
            flag_wr_all = 1'($urandom); alu_result = 16'($urandom);
            step();
            check("halt_hold_pc", int'(pc), 16'h0020);
        end
        rst_n = 0;
        step();
        rst_n = 1; idle();
        check("rst_from_halt", int'({halted, pc}), 0);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst_n       = ($urandom_range(0, 149) != 0);
            en          = ($urandom_range(0, 7) != 0);
            alu_result  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            alu_ovfl    = 1'($urandom);
            flag_wr_all = 1'($urandom);
            flag_wr_z   = 1'($urandom);
            branch      = 1'($urandom);
            branch_reg  = ($urandom_range(0, 3) == 0);
            ccc         = 3'($urandom);
            imm9        = 9'($urandom);
            rs_data     = 16'($urandom);
            halt        = ($urandom_range(0, 99) == 0);
            step();
        end
        idle();
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
